dtw_core_ref_reader: RTL and testbench

DTW_CORE_REF_READER -- requirements
Module: dtw_core_ref_reader

---
 rtl/dtw_core_pkg.sv | 14 +
 rtl/dtw_ref_skid_buf.sv | 71 +++++++
 rtl/dtw_core_ref_reader.sv | 153 +++++++++++++++
 tb/tb_dtw_core_ref_reader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_core_pkg.sv
// Shared definitions for the DTW reference reader: FSM state encoding and skid buffer sizing.
package dtw_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } rd_state_e;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_PTR_W = $clog2(SKID_DEPTH);
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/dtw_ref_skid_buf.sv
// Two-entry skid buffer between the reference memory read port and the destination FIFO.
// Upstream never pushes into a full buffer; flush empties it in one cycle.
module dtw_ref_skid_buf
  import dtw_core_pkg::*;
#(
  parameter int DATA_WIDTH = 16
)
(
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  flush_in,
  input  logic                  push_in,
  input  logic [DATA_WIDTH-1:0] push_data_in,
  input  logic                  pop_in,
  output logic [SKID_CNT_W-1:0] count_out,
  output logic [DATA_WIDTH-1:0] head_out
);

  logic [SKID_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [SKID_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [SKID_CNT_W-1:0] count_q, count_d;
  logic                  do_push;
  logic                  do_pop;
  logic [DATA_WIDTH-1:0] entry_data [SKID_DEPTH];

  assign do_push = push_in && !flush_in;
  assign do_pop  = pop_in && !flush_in && (count_q != '0);

  for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
    logic [DATA_WIDTH-1:0] data_q;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        data_q <= '0;
      end else if (do_push && (wr_ptr_q == SKID_PTR_W'(gi))) begin
        data_q <= push_data_in;
      end
    end
    assign entry_data[gi] = data_q;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + SKID_PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + SKID_PTR_W'(1);
      count_d = count_q + SKID_CNT_W'(do_push) - SKID_CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_out = count_q;
  assign head_out  = entry_data[rd_ptr_q];

endmodule

// File: rtl/dtw_core_ref_reader.sv
// Streams ref_len samples from the reference memory into a destination FIFO through a skid buffer.
// Optional feature macro DTW_REF_READER_LOOP_EN adds loop_in for endless wrap-around streaming.
module dtw_core_ref_reader
  import dtw_core_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH       = 32,
  parameter int REFMEM_PTR_WIDTH = 20
)
(
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        start_in,
  input  logic                        abort_in,
  input  logic [ADDR_WIDTH-1:0]       ref_len_in,
  input  logic                        ref_load_done_in,
`ifdef DTW_REF_READER_LOOP_EN
  input  logic                        loop_in,
`endif
  output logic                        busy_out,
  output logic                        done_out,
  output logic                        err_out,
  output logic [REFMEM_PTR_WIDTH-1:0] ref_addr_out,
  input  logic [DATA_WIDTH-1:0]       ref_data_in,
  output logic                        dst_fifo_wren_out,
  output logic [DATA_WIDTH-1:0]       dst_fifo_data_out,
  input  logic                        dst_fifo_full_in
);

  localparam logic [REFMEM_PTR_WIDTH-1:0] PTR_ONE = REFMEM_PTR_WIDTH'(1);

  rd_state_e                   state_q, state_d;
  logic [REFMEM_PTR_WIDTH-1:0] addr_q, addr_d;
  logic [REFMEM_PTR_WIDTH-1:0] len_q, len_d;
  logic                        loop_q, loop_d;
  logic                        rd_vld_q, rd_vld_d;
  logic                        done_zero_q, done_zero_d;
  logic                        err_q, err_d;

  logic [REFMEM_PTR_WIDTH-1:0] len_trunc;
  logic [SKID_CNT_W-1:0]       skid_count;
  logic [SKID_CNT_W-1:0]       used_slots;
  logic [DATA_WIDTH-1:0]       skid_head;
  logic                        loop_req;
  logic                        pop;
  logic                        issue;
  logic                        last_issue;
  logic                        drain_done;
  logic                        start_ok;

  assign len_trunc = ref_len_in[REFMEM_PTR_WIDTH-1:0];

  if (ADDR_WIDTH > REFMEM_PTR_WIDTH) begin : g_len_hi
    logic unused_len_hi;
    assign unused_len_hi = ^ref_len_in[ADDR_WIDTH-1:REFMEM_PTR_WIDTH];
  end

`ifdef DTW_REF_READER_LOOP_EN
  assign loop_req = loop_in;
`else
  assign loop_req = 1'b0;
`endif

  // Slots are counted after this cycle's downstream write so a steady stream keeps one read per cycle.
  always_comb begin
    pop        = (skid_count != '0) && !dst_fifo_full_in;
    used_slots = skid_count - SKID_CNT_W'(pop) + SKID_CNT_W'(rd_vld_q);
    issue      = (state_q == ST_STREAM) && (used_slots < SKID_CNT_W'(SKID_DEPTH));
    last_issue = issue && (addr_q == len_q - PTR_ONE);
    drain_done = (state_q == ST_DRAIN) && !rd_vld_q && (skid_count == SKID_CNT_W'(1))
                 && pop && !abort_in;
    start_ok   = (state_q == ST_IDLE) && start_in && !abort_in;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    loop_d      = loop_q;
    rd_vld_d    = issue && !abort_in;
    done_zero_d = start_ok && ref_load_done_in && (len_trunc == '0);
    err_d       = start_ok && !ref_load_done_in;
    if (abort_in) begin
      state_d = ST_IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok && ref_load_done_in && (len_trunc != '0)) begin
            state_d = ST_STREAM;
            addr_d  = '0;
            len_d   = len_trunc;
            loop_d  = loop_req;
          end
        end
        ST_STREAM: begin
          if (last_issue) begin
            addr_d = '0;
            if (!loop_q) state_d = ST_DRAIN;
          end else if (issue) begin
            addr_d = addr_q + PTR_ONE;
          end
        end
        ST_DRAIN: begin
          if (drain_done) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      done_zero_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      loop_q      <= loop_d;
      rd_vld_q    <= rd_vld_d;
      done_zero_q <= done_zero_d;
      err_q       <= err_d;
    end
  end

  // Memory data for the address issued last cycle is valid now; capture it.
  dtw_ref_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .flush_in    (abort_in),
    .push_in     (rd_vld_q),
    .push_data_in(ref_data_in),
    .pop_in      (pop),
    .count_out   (skid_count),
    .head_out    (skid_head)
  );

  assign busy_out          = (state_q != ST_IDLE);
  assign done_out          = done_zero_q || drain_done;
  assign err_out           = err_q;
  assign ref_addr_out      = addr_q;
  assign dst_fifo_wren_out = pop;
  assign dst_fifo_data_out = skid_head;

endmodule

// File: tb/tb_dtw_core_ref_reader.sv
// Self-checking bench for dtw_core_ref_reader: queue-based reference model plus directed scenarios.
module tb_dtw_core_ref_reader;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int PW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          load_done = 1'b0;
  logic          full = 1'b0;
  logic [AW-1:0] ref_len = '0;
  logic [PW-1:0] ref_addr;
  logic [DW-1:0] ref_data = '0;
  logic [DW-1:0] fifo_data;
  logic          busy, done, err, wren;
  logic [DW-1:0] mem [256];

  int n_tests = 0;
  int n_fail = 0;
  int wr_count = 0;
  int done_count = 0;
  int err_count = 0;

  logic [DW-1:0] exp_q [$];
  bit stream_active = 0;
  bit done_zero_pend = 0;
  bit err_pend = 0;
  bit m_active;
  bit m_exp_done;

  dtw_core_ref_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REFMEM_PTR_WIDTH(PW)
  ) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .start_in         (start),
    .abort_in         (abort),
    .ref_len_in       (ref_len),
    .ref_load_done_in (load_done),
`ifdef DTW_REF_READER_LOOP_EN
    .loop_in          (1'b0),
`endif
    .busy_out         (busy),
    .done_out         (done),
    .err_out          (err),
    .ref_addr_out     (ref_addr),
    .ref_data_in      (ref_data),
    .dst_fifo_wren_out(wren),
    .dst_fifo_data_out(fifo_data),
    .dst_fifo_full_in (full)
  );

  always #5 clk = ~clk;

  // Reference memory with a registered read port.
  always @(posedge clk) ref_data <= mem[ref_addr[7:0]];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int k;
    k = 0;
    tick();
    while (busy && k < max_cyc) begin
      tick();
      k++;
    end
    check(name, busy, 0);
  endtask

  // Model: every accepted start queues the samples it must deliver; writes must match in order,
  // done is due exactly when the last queued sample of an unaborted stream is written.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ctl", {28'd0, busy, done, err, wren}, 32'd0);
      check("rst_addr", ref_addr, 0);
      check("rst_data", fifo_data, 0);
      exp_q.delete();
      stream_active  = 0;
      done_zero_pend = 0;
      err_pend       = 0;
    end else begin
      check("busy", busy, stream_active);
      m_exp_done = done_zero_pend;
      if (wren) begin
        wr_count++;
        check("wr_while_full", full, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", wren, 0);
        end else begin
          check("wr_data", fifo_data, exp_q.pop_front());
          if (exp_q.size() == 0 && stream_active && !abort) m_exp_done = 1;
        end
      end
      check("done", done, m_exp_done);
      check("err", err, err_pend);
      if (done) done_count++;
      if (err) err_count++;
      m_active       = stream_active;
      done_zero_pend = 0;
      err_pend       = 0;
      if (m_exp_done) stream_active = 0;
      if (abort) begin
        stream_active = 0;
        exp_q.delete();
      end else if (start && !m_active) begin
        if (!load_done) err_pend = 1;
        else if (ref_len[PW-1:0] == '0) done_zero_pend = 1;
        else begin
          stream_active = 1;
          for (int i = 0; i < int'(ref_len[PW-1:0]); i++) exp_q.push_back(mem[i]);
        end
      end
    end
  end

  initial begin
    logic [8:0]    wv, dnv, bv;
    logic [DW-1:0] d3, d6, fdat;
    int            base_wr, base_done, base_err, cnt, first;
    bit            hit;

    for (int i = 0; i < 256; i++) mem[i] = 16'hC000 + 16'(i);
    mem[0] = 16'h0011; mem[1] = 16'h0022; mem[2] = 16'h0033; mem[3] = 16'h0044;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_wren", wren, 0);
    rst_n = 1'b1;
    load_done = 1'b1;
    tick(); tick();

    // len=4, full=0: writes on cycles 3..6, done on 6, busy falls on 7
    wv = '0; dnv = '0; bv = '0; d3 = '0; d6 = '0;
    start = 1; ref_len = 4;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      wv[k] = wren; dnv[k] = done; bv[k] = busy;
      if (k == 3) d3 = fifo_data;
      if (k == 6) d6 = fifo_data;
      @(posedge clk); #1;
      start = 0;
    end
    check("len4_wren_cycles", wv, 9'h078);
    check("len4_done_cycle", dnv, 9'h040);
    check("len4_busy_cycles", bv, 9'h07E);
    check("len4_first_data", d3, 16'h0011);
    check("len4_last_data", d6, 16'h0044);

    // len=8 with full toggling every cycle; a start while busy is ignored
    base_wr = wr_count; base_done = done_count;
    start = 1; ref_len = 8; full = 1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      full = ~full;
      start = (k == 3);
      ref_len = (k == 3) ? 2 : 8;
      if (k > 3 && !busy) break;
    end
    start = 0; full = 0;
    check("toggle_idle", busy, 0);
    check("toggle_writes", wr_count - base_wr, 8);
    check("toggle_done", done_count - base_done, 1);
    tick(); tick();

    // len=5 with full held for 20 cycles: skid fills, address stalls at 2
    base_wr = wr_count;
    start = 1; ref_len = 5; full = 1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      start = 0;
      if (k == 10) begin
        check("stall_addr", ref_addr, 2);
        check("stall_head", fifo_data, 16'h0011);
        check("stall_wren", wren, 0);
      end
    end
    full = 0;
    wait_idle("stall_drain_idle", 40);
    check("stall_writes", wr_count - base_wr, 5);
    tick();

    // start without loaded reference: err pulse, stays idle
    base_wr = wr_count; base_err = err_count;
    load_done = 0; start = 1; ref_len = 4;
    tick();
    start = 0;
    check("noload_err", err, 1);
    check("noload_busy", busy, 0);
    repeat (3) tick();
    check("noload_busy_later", busy, 0);
    check("noload_writes", wr_count - base_wr, 0);
    check("noload_err_count", err_count - base_err, 1);
    load_done = 1;

    // len=0 and a length whose only set bit is above the pointer width
    start = 1; ref_len = 0;
    tick();
    start = 0;
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    tick();
    start = 1; ref_len = 32'h0010_0000;
    tick();
    start = 0;
    check("lentrunc_done", done, 1);
    check("lentrunc_busy", busy, 0);
    tick();

    // len=100, abort on the 10th write, then restart from address 0
    base_wr = wr_count; base_done = done_count;
    cnt = 0; hit = 0;
    start = 1; ref_len = 100;
    for (int k = 0; k < 200 && !hit; k++) begin
      tick();
      start = 0;
      if (wren) cnt++;
      if (cnt == 10) begin
        abort = 1;
        hit = 1;
      end
    end
    check("abort_reached", hit, 1);
    tick();
    abort = 0;
    check("abort_busy", busy, 0);
    check("abort_writes", wr_count - base_wr, 10);
    repeat (10) tick();
    check("abort_no_more_writes", wr_count - base_wr, 10);
    check("abort_no_done", done_count - base_done, 0);
    first = -1; fdat = '0;
    start = 1; ref_len = 3;
    for (int k = 1; k <= 8; k++) begin
      tick();
      start = 0;
      if (wren && first < 0) begin
        first = k;
        fdat = fifo_data;
      end
    end
    check("restart_first_cycle", first, 3);
    check("restart_first_data", fdat, 16'h0011);
    wait_idle("restart_idle", 20);

    // reset pulled mid-stream with len=16
    start = 1; ref_len = 16;
    for (int k = 1; k <= 6; k++) begin
      tick();
      start = 0;
    end
    rst_n = 0;
    #1;
    check("midrst_wren", wren, 0);
    check("midrst_busy", busy, 0);
    check("midrst_addr", ref_addr, 0);
    check("midrst_data", fifo_data, 0);
    tick(); tick();
    rst_n = 1;
    base_wr = wr_count;
    repeat (10) tick();
    check("postrst_writes", wr_count - base_wr, 0);
    check("postrst_busy", busy, 0);
    start = 1; ref_len = 2;
    wait_idle("postrst_stream_idle", 20);
    start = 0;
    check("postrst_stream_writes", wr_count - base_wr, 2);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, required finished");
    $fatal(1, "timeout");
  end

endmodule
